// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen: syncs, blank, coordinates, start pulses and frame count.
// With TEST_PATTERN_EN defined, the bundle also carries the 8-bit RGB test-pattern channels.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          vga_hs_n;
  logic          vga_vs_n;
  logic          vga_blank_n;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_cnt;
`ifdef TEST_PATTERN_EN
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;
`endif

  modport master (
    output vga_hs_n, vga_vs_n, vga_blank_n, pixel_x, pixel_y,
    output line_start, frame_start, frame_cnt
`ifdef TEST_PATTERN_EN
    , output vga_r, vga_g, vga_b
`endif
  );

  modport slave (
    input vga_hs_n, vga_vs_n, vga_blank_n, pixel_x, pixel_y,
    input line_start, frame_start, frame_cnt
`ifdef TEST_PATTERN_EN
    , input vga_r, vga_g, vga_b
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scans an HTOTAL x VTOTAL grid and drives registered, mutually aligned
// syncs, blank, coordinates and start pulses. Optional macro TEST_PATTERN_EN adds an 8-bar colour pattern.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic              pixel_clk,
  input  logic              pixel_rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HTOTAL);
  localparam int YW     = $clog2(VTOTAL);

  localparam logic [XW-1:0] X_LAST     = XW'(HTOTAL - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(VTOTAL - 1);
  localparam logic [XW-1:0] X_DISP     = XW'(HDISP);
  localparam logic [YW-1:0] Y_DISP     = YW'(VDISP);
  localparam logic [XW-1:0] HSYNC_BEG  = XW'(HDISP + HFP);
  localparam logic [XW-1:0] HSYNC_END  = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0] VSYNC_BEG  = YW'(VDISP + VFP);
  localparam logic [YW-1:0] VSYNC_END  = YW'(VDISP + VFP + VPULSE);

  // ST_RESET holds for the first clock after reset release so that cycle presents (0,0).
  typedef enum logic {
    ST_RESET,
    ST_RUN
  } state_e;

  state_e        state_q,       state_d;
  logic [XW-1:0] x_q,           x_d;
  logic [YW-1:0] y_q,           y_d;
  logic          hs_n_q,        hs_n_d;
  logic          vs_n_q,        vs_n_d;
  logic          blank_n_q,     blank_n_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q,   frame_cnt_d;

`ifdef TEST_PATTERN_EN
  localparam logic [XW-1:0] BAR_W = XW'(HDISP / 8);

  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  bar_idx;
  logic [2:0]  bar_rgb;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_RESET: begin
        x_d     = '0;
        y_d     = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d         = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Outputs are decoded from the next position so they register in step with the counters.
    hs_n_d        = !((x_d >= HSYNC_BEG) && (x_d < HSYNC_END));
    vs_n_d        = !((y_d >= VSYNC_BEG) && (y_d < VSYNC_END));
    blank_n_d     = (x_d < X_DISP) && (y_d < Y_DISP);
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

`ifdef TEST_PATTERN_EN
  always_comb begin
    bar_idx = 3'(x_d / BAR_W);
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;  // white
      3'd1:    bar_rgb = 3'b110;  // yellow
      3'd2:    bar_rgb = 3'b011;  // cyan
      3'd3:    bar_rgb = 3'b010;  // green
      3'd4:    bar_rgb = 3'b101;  // magenta
      3'd5:    bar_rgb = 3'b100;  // red
      3'd6:    bar_rgb = 3'b001;  // blue
      default: bar_rgb = 3'b000;  // black
    endcase
    rgb_d = '0;
    if (blank_n_d) begin
      rgb_d = {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
    end
  end
`endif

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; reset is synchronous.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state_q       <= ST_RESET;
      x_q           <= '0;
      y_q           <= '0;
      hs_n_q        <= 1'b1;
      vs_n_q        <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_n_q        <= hs_n_d;
      vs_n_q        <= vs_n_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef TEST_PATTERN_EN
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga.vga_r = rgb_q[23:16];
  assign vga.vga_g = rgb_q[15:8];
  assign vga.vga_b = rgb_q[7:0];
`endif

  assign vga.vga_hs_n    = hs_n_q;
  assign vga.vga_vs_n    = vs_n_q;
  assign vga.vga_blank_n = blank_n_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunk-grid instance (so whole frames and the
// 256-frame wrap fit in a short run) are compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  // Full-size grid
  localparam int A_HD = 800, A_HF = 40, A_HP = 48, A_HB = 40;
  localparam int A_VD = 480, A_VF = 13, A_VP = 3,  A_VB = 29;
  localparam int A_HT = A_HD + A_HF + A_HP + A_HB;
  localparam int A_VT = A_VD + A_VF + A_VP + A_VB;
  localparam int A_XW = $clog2(A_HT);
  localparam int A_YW = $clog2(A_VT);

  // Shrunk grid: 24 x 12 = 288 cycles per frame
  localparam int B_HD = 16, B_HF = 2, B_HP = 3, B_HB = 3;
  localparam int B_VD = 6,  B_VF = 2, B_VP = 2, B_VB = 2;
  localparam int B_HT = B_HD + B_HF + B_HP + B_HB;
  localparam int B_VT = B_VD + B_VF + B_VP + B_VB;
  localparam int B_XW = $clog2(B_HT);
  localparam int B_YW = $clog2(B_VT);

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int vectors     = 0;
  int miscompares = 0;

  vga_timing_gen_if #(.XW(A_XW), .YW(A_YW)) if_a ();
  vga_timing_gen_if #(.XW(B_XW), .YW(B_YW)) if_b ();

  vga_timing_gen u_dut_a (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_a_n),
    .vga         (if_a.master)
  );

  vga_timing_gen #(
    .HDISP(B_HD), .HFP(B_HF), .HPULSE(B_HP), .HBP(B_HB),
    .VDISP(B_VD), .VFP(B_VF), .VPULSE(B_VP), .VBP(B_VB)
  ) u_dut_b (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_b_n),
    .vga         (if_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs from raster arithmetic: t is the number of clocks since the first running cycle.
  // Packing: {x[11:0], y[11:0], hs_n, vs_n, blank_n, line_start, frame_start, frame_cnt[7:0], rgb[23:0]}
  function automatic logic [63:0] model(input int hd, input int hf, input int hp, input int hb,
                                        input int vd, input int vf, input int vp, input int vb,
                                        input bit in_rst, input int t);
    int ht, vt, x, y, fc;
    logic hs_n, vs_n, bl, ls, fs;
    logic [2:0]  c;
    logic [23:0] rgb;
    if (in_rst) return {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 24'd0};
    ht   = hd + hf + hp + hb;
    vt   = vd + vf + vp + vb;
    x    = t % ht;
    y    = (t / ht) % vt;
    fc   = (t / (ht * vt)) % 256;
    hs_n = !(x >= hd + hf && x < hd + hf + hp);
    vs_n = !(y >= vd + vf && y < vd + vf + vp);
    bl   = (x < hd) && (y < vd);
    ls   = (x == 0);
    fs   = (x == 0) && (y == 0);
    rgb  = 24'd0;
`ifdef TEST_PATTERN_EN
    if (bl) begin
      case (x / (hd / 8))
        0:       c = 3'b111;
        1:       c = 3'b110;
        2:       c = 3'b011;
        3:       c = 3'b010;
        4:       c = 3'b101;
        5:       c = 3'b100;
        6:       c = 3'b001;
        default: c = 3'b000;
      endcase
      rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    end
`else
    c = 3'b000;
    rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
`endif
    return {12'(x), 12'(y), hs_n, vs_n, bl, ls, fs, 8'(fc), rgb};
  endfunction

  logic [23:0] rgb_a, rgb_b;
`ifdef TEST_PATTERN_EN
  assign rgb_a = {if_a.vga_r, if_a.vga_g, if_a.vga_b};
  assign rgb_b = {if_b.vga_r, if_b.vga_g, if_b.vga_b};
`else
  assign rgb_a = 24'd0;
  assign rgb_b = 24'd0;
`endif

  logic [63:0] obs_a, obs_b;
  assign obs_a = {3'd0, 12'(if_a.pixel_x), 12'(if_a.pixel_y), if_a.vga_hs_n, if_a.vga_vs_n,
                  if_a.vga_blank_n, if_a.line_start, if_a.frame_start, if_a.frame_cnt, rgb_a};
  assign obs_b = {3'd0, 12'(if_b.pixel_x), 12'(if_b.pixel_y), if_b.vga_hs_n, if_b.vga_vs_n,
                  if_b.vga_blank_n, if_b.line_start, if_b.frame_start, if_b.frame_cnt, rgb_b};

  // Model time base: tracks what each reset input did at every rising edge.
  bit valid_a = 0, in_rst_a = 1;
  bit valid_b = 0, in_rst_b = 1;
  int t_a = 0, t_b = 0;

  always @(posedge clk) begin
    if (!rst_a_n) begin
      in_rst_a <= 1'b1;
      valid_a  <= 1'b1;
    end else if (valid_a) begin
      if (in_rst_a) begin
        in_rst_a <= 1'b0;
        t_a      <= 0;
      end else begin
        t_a <= t_a + 1;
      end
    end
    if (!rst_b_n) begin
      in_rst_b <= 1'b1;
      valid_b  <= 1'b1;
    end else if (valid_b) begin
      if (in_rst_b) begin
        in_rst_b <= 1'b0;
        t_b      <= 0;
      end else begin
        t_b <= t_b + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (valid_a) check("raster_full", obs_a, model(A_HD, A_HF, A_HP, A_HB, A_VD, A_VF, A_VP, A_VB, in_rst_a, t_a));
    if (valid_b) check("raster_small", obs_b, model(B_HD, B_HF, B_HP, B_HB, B_VD, B_VF, B_VP, B_VB, in_rst_b, t_b));
  end

  task automatic seq_a();
    int n;
    repeat (3000) @(negedge clk);
    // Reset during horizontal sync at x=850
    n = 0;
    while (!(!in_rst_a && (t_a % A_HT) == 850) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_full_x850", 64'(!in_rst_a && (t_a % A_HT) == 850), 64'd1);
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (1200) @(negedge clk);
    // Randomly timed resets of random length
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(1, 6000)) @(negedge clk);
      rst_a_n = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_a_n = 1'b1;
    end
    repeat (1000) @(negedge clk);
  endtask

  task automatic seq_b();
    int n;
    // 256 full frames plus margin so frame_cnt wraps back to 0
    repeat (B_HT * B_VT * 257 + 10) @(negedge clk);
    // Reset with both syncs low: x=19 (hsync), y=8 (vsync)
    n = 0;
    while (!(!in_rst_b && (t_b % B_HT) == 19 && ((t_b / B_HT) % B_VT) == 8) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_small_syncs", 64'(!in_rst_b && (t_b % B_HT) == 19 && ((t_b / B_HT) % B_VT) == 8), 64'd1);
    check("small_syncs_low", {62'd0, if_b.vga_hs_n, if_b.vga_vs_n}, 64'd0);
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
